// File: rtl/bridge_pkg.sv
// Shared types and constants for the data-side system bridge: FSM states,
// MIPS ExcCode values and the default three-device memory map.
package bridge_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  localparam logic [4:0] EXC_NONE = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_DBE  = 5'd7;

  // Device 0 = data memory (16 KiB), 1 = timers, 2 = I/O.
  localparam int DEF_NDEV = 3;
  localparam logic [DEF_NDEV*32-1:0] DEF_DEV_BASE =
    {32'h0000_7F10, 32'h0000_7F00, 32'h0000_0000};
  localparam logic [DEF_NDEV*32-1:0] DEF_DEV_MASK =
    {32'hFFFF_FFF0, 32'hFFFF_FFF0, 32'hFFFF_C000};

endpackage

// File: rtl/bridge_addr_decoder.sv
// Combinational base/mask address decoder; the lowest-indexed matching
// window wins when windows overlap.
module bridge_addr_decoder
  import bridge_pkg::*;
#(
  parameter int NDEV = DEF_NDEV,
  parameter int AW   = 32,
  parameter logic [NDEV*AW-1:0] DEV_BASE = DEF_DEV_BASE,
  parameter logic [NDEV*AW-1:0] DEV_MASK = DEF_DEV_MASK,
  localparam int IW = (NDEV > 1) ? $clog2(NDEV) : 1
) (
  input  logic [AW-1:0]   addr,
  output logic            hit,
  output logic [NDEV-1:0] onehot,
  output logic [IW-1:0]   index
);

  // Scanning downwards lets the lowest matching index overwrite the others.
  always_comb begin
    hit    = 1'b0;
    onehot = '0;
    index  = '0;
    for (int i = NDEV - 1; i >= 0; i--) begin
      if ((addr & DEV_MASK[i*AW +: AW]) == DEV_BASE[i*AW +: AW]) begin
        hit       = 1'b1;
        onehot    = '0;
        onehot[i] = 1'b1;
        index     = IW'(i);
      end
    end
  end

endmodule

// File: rtl/sys_bridge.sv
// Data-side bridge from the MIPS memory stage to NDEV memory-mapped devices:
// one access at a time, registered response, AdEL/AdES/DBE bus exceptions.
module sys_bridge
  import bridge_pkg::*;
#(
  parameter int NDEV    = DEF_NDEV,
  parameter int DW      = 32,
  parameter int AW      = 32,
  parameter int TIMEOUT = 15,
  parameter logic [NDEV*AW-1:0] DEV_BASE = DEF_DEV_BASE,
  parameter logic [NDEV*AW-1:0] DEV_MASK = DEF_DEV_MASK
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             cpu_req,
  input  logic             cpu_we,
  input  logic [AW-1:0]    cpu_addr,
  input  logic [DW-1:0]    cpu_wdata,
  input  logic [3:0]       cpu_be,
  output logic             cpu_ready,
  output logic [DW-1:0]    cpu_rdata,
  output logic             cpu_exc,
  output logic [4:0]       cpu_exc_code,
  output logic [NDEV-1:0]  dev_sel,
  output logic             dev_we,
  output logic [AW-1:0]    dev_addr,
  output logic [DW-1:0]    dev_wdata,
  output logic [3:0]       dev_be,
  input  logic [NDEV-1:0]  dev_ready,
  input  logic [NDEV*DW-1:0] dev_rdata,
  output state_t           dbg_state
);

  // Handshake: cpu_req is sampled only in IDLE and the CPU stalls until the
  // single-cycle cpu_ready pulse; a device completes by raising its dev_ready
  // bit while selected, and dev_ready from unselected devices is ignored.

  localparam int IW = (NDEV > 1) ? $clog2(NDEV) : 1;
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t            state, state_nxt;
  logic [7:0]        cnt, cnt_nxt;
  logic [IW-1:0]     sel_idx, sel_idx_nxt;
  logic [NDEV-1:0]   sel_nxt;
  logic              ready_nxt, exc_nxt, latch;
  logic [4:0]        code_nxt;
  logic [DW-1:0]     rdata_nxt;
  logic              dec_hit;
  logic [NDEV-1:0]   dec_onehot;
  logic [IW-1:0]     dec_index;
  logic [DW-1:0]     rdata_arr [NDEV];

  bridge_addr_decoder #(
    .NDEV     (NDEV),
    .AW       (AW),
    .DEV_BASE (DEV_BASE),
    .DEV_MASK (DEV_MASK)
  ) u_dec (
    .addr   (cpu_addr),
    .hit    (dec_hit),
    .onehot (dec_onehot),
    .index  (dec_index)
  );

  for (genvar g = 0; g < NDEV; g++) begin : g_rdata
    assign rdata_arr[g] = dev_rdata[g*DW +: DW];
  end

  assign dbg_state = state;

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    sel_idx_nxt = sel_idx;
    sel_nxt     = dev_sel;
    ready_nxt   = 1'b0;
    exc_nxt     = 1'b0;
    code_nxt    = EXC_NONE;
    rdata_nxt   = cpu_rdata;
    latch       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (cpu_req) begin
          latch = 1'b1;
          if (dec_hit) begin
            state_nxt   = ST_ACCESS;
            sel_nxt     = dec_onehot;
            sel_idx_nxt = dec_index;
            cnt_nxt     = '0;
          end else begin
            state_nxt = ST_RESP;
            ready_nxt = 1'b1;
            exc_nxt   = 1'b1;
            code_nxt  = cpu_we ? EXC_ADES : EXC_ADEL;
          end
        end
      end
      ST_ACCESS: begin
        cnt_nxt = cnt + 8'd1;
        // Ready is tested first so it wins over a coincident timeout.
        if (dev_ready[sel_idx]) begin
          state_nxt = ST_RESP;
          ready_nxt = 1'b1;
          sel_nxt   = '0;
          if (!dev_we) rdata_nxt = rdata_arr[sel_idx];
        end else if (cnt == CNT_LAST) begin
          state_nxt = ST_RESP;
          ready_nxt = 1'b1;
          sel_nxt   = '0;
          exc_nxt   = 1'b1;
          code_nxt  = EXC_DBE;
        end
      end
      ST_RESP: begin
        state_nxt = ST_IDLE;
        sel_nxt   = '0;
      end
      default: begin
        state_nxt = ST_IDLE;
        sel_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= ST_IDLE;
      cnt          <= '0;
      sel_idx      <= '0;
      dev_sel      <= '0;
      cpu_ready    <= 1'b0;
      cpu_exc      <= 1'b0;
      cpu_exc_code <= EXC_NONE;
      cpu_rdata    <= '0;
      dev_we       <= 1'b0;
      dev_addr     <= '0;
      dev_wdata    <= '0;
      dev_be       <= '0;
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      sel_idx      <= sel_idx_nxt;
      dev_sel      <= sel_nxt;
      cpu_ready    <= ready_nxt;
      cpu_exc      <= exc_nxt;
      cpu_exc_code <= code_nxt;
      cpu_rdata    <= rdata_nxt;
      if (latch) begin
        dev_we    <= cpu_we;
        dev_addr  <= cpu_addr;
        dev_wdata <= cpu_wdata;
        dev_be    <= cpu_be;
      end
    end
  end

endmodule
